count_event_fifo: RTL and testbench

Downstream consumer of the 4-bit counter (`Q_`, `rco_`, `load_`). Detects rising edges of the counter's ripple-carry and load strobes and records each event together with the counter value in a small FIFO. Records are delivered to a reader over a valid/ready interface. Used by the scoreboard/checker side to get a time-ordered log of wrap and load events without polling `Q_` every cycle.

---
 rtl/count_event_fifo.sv | 106 ++++++++++
 tb/tb_count_event_fifo.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_event_fifo.sv
// Edge-triggered event log for the 4-bit counter: rco/load rises go into a FWFT FIFO.
// Define COUNT_EVENT_TIMESTAMP_EN to add an 8-bit cycle timestamp to each record.
module count_event_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
`ifdef COUNT_EVENT_TIMESTAMP_EN
    localparam int RW   = 14
`else
    localparam int RW   = 6
`endif
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cap_en,
    input  logic [3:0]    Q_,
    input  logic          rco_,
    input  logic          load_,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [RW-1:0] out_data,
    output logic [AW:0]   level,
    output logic          overflow,
    output logic [7:0]    drop_cnt
);

    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic          rco_q;
    logic          load_q;
    logic          rco_ev;
    logic          load_ev;
    logic          push_req;
    logic          push_ok;
    logic          pop;
    logic          drop;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [RW-1:0] rec;
    logic [RW-1:0] mem [DEPTH];

`ifdef COUNT_EVENT_TIMESTAMP_EN
    logic [7:0]    ts;
`endif

    assign rco_ev   = rco_ & ~rco_q;
    assign load_ev  = load_ & ~load_q;
    assign push_req = cap_en & (rco_ev | load_ev);
    assign pop      = out_valid & out_ready;
    // A pop in the same cycle frees the slot the push needs.
    assign push_ok  = push_req & ((level != FULL_LVL) | pop);
    assign drop     = push_req & ~push_ok;

`ifdef COUNT_EVENT_TIMESTAMP_EN
    assign rec = {ts, load_ev, rco_ev, Q_};
`else
    assign rec = {load_ev, rco_ev, Q_};
`endif

    assign out_valid = (level != '0);
    assign out_data  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            rco_q    <= 1'b0;
            load_q   <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
            drop_cnt <= 8'd0;
`ifdef COUNT_EVENT_TIMESTAMP_EN
            ts       <= 8'd0;
`endif
        end else begin
            rco_q  <= rco_;
            load_q <= load_;
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   level <= level + (AW + 1)'(1);
                2'b01:   level <= level - (AW + 1)'(1);
                default: level <= level;
            endcase
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
            end
`ifdef COUNT_EVENT_TIMESTAMP_EN
            ts <= ts + 8'd1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !reset) begin
            mem[wr_ptr] <= rec;
        end
    end

endmodule

// File: tb/tb_count_event_fifo.sv
// Directed self-checking bench for count_event_fifo (DEPTH = 8).
// Timestamp scenario runs only when COUNT_EVENT_TIMESTAMP_EN is defined.
module tb_count_event_fifo;

`ifdef COUNT_EVENT_TIMESTAMP_EN
    localparam int RW = 14;
`else
    localparam int RW = 6;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cap_en = 1'b0;
    logic [3:0]    q = 4'h0;
    logic          rco = 1'b0;
    logic          load = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [RW-1:0] out_data;
    logic [3:0]    level;
    logic          overflow;
    logic [7:0]    drop_cnt;

    int errors = 0;
    int checks = 0;

    count_event_fifo #(.DEPTH(8), .AW(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .cap_en    (cap_en),
        .Q_        (q),
        .rco_      (rco),
        .load_     (load),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rco = 1'b0;
        load = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic pulse_rco(input logic [3:0] v);
        q = v;
        rco = 1'b1;
        tick();
        rco = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b want 0", out_valid);
        end
        checks++;
        if (level !== 4'd0) begin
            errors++;
            $display("FAIL reset_level: got %0d want 0", level);
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf: got %b want 0", overflow);
        end
        checks++;
        if (drop_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_drop: got %0d want 0", drop_cnt);
        end
    endtask

    task automatic test_single_rco();
        cap_en = 1'b1;
        out_ready = 1'b0;
        q = 4'hF;
        rco = 1'b1;
        tick();
        rco = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_valid: got %b want 1", out_valid);
        end
        checks++;
        if (out_data[5:0] !== 6'b01_1111) begin
            errors++;
            $display("FAIL single_data: got %b want 011111", out_data[5:0]);
        end
        checks++;
        if (level !== 4'd1) begin
            errors++;
            $display("FAIL single_level: got %0d want 1", level);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || level !== 4'd0) begin
            errors++;
            $display("FAIL single_pop: got v=%b l=%0d want v=0 l=0",
                     out_valid, level);
        end
        // Popping an empty FIFO must not underflow.
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (level !== 4'd0) begin
            errors++;
            $display("FAIL empty_pop: got %0d want 0", level);
        end
    endtask

    task automatic test_held_and_both();
        q = 4'h2;
        rco = 1'b1;
        tick();
        tick();
        tick();
        rco = 1'b0;
        tick();
        checks++;
        if (level !== 4'd1 || out_data[5:0] !== 6'b01_0010) begin
            errors++;
            $display("FAIL held: got l=%0d d=%b want l=1 d=010010",
                     level, out_data[5:0]);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        q = 4'h3;
        rco = 1'b1;
        load = 1'b1;
        tick();
        rco = 1'b0;
        load = 1'b0;
        tick();
        checks++;
        if (level !== 4'd1 || out_data[5:0] !== 6'b11_0011) begin
            errors++;
            $display("FAIL both: got l=%0d d=%b want l=1 d=110011",
                     level, out_data[5:0]);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        q = 4'h5;
        load = 1'b1;
        tick();
        load = 1'b0;
        checks++;
        if (out_data[5:0] !== 6'b10_0101) begin
            errors++;
            $display("FAIL load_only: got %b want 100101", out_data[5:0]);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        // Rise while disabled updates history, so enabling later adds nothing.
        cap_en = 1'b0;
        rco = 1'b1;
        tick();
        cap_en = 1'b1;
        tick();
        rco = 1'b0;
        tick();
        checks++;
        if (level !== 4'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL cap_en_gate: got l=%0d want 0", level);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        cap_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            pulse_rco(4'(i));
        end
        checks++;
        if (level !== 4'd8) begin
            errors++;
            $display("FAIL ovf_level: got %0d want 8", level);
        end
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_flag: got %b want 1", overflow);
        end
        checks++;
        if (drop_cnt !== 8'd2) begin
            errors++;
            $display("FAIL ovf_drop: got %0d want 2", drop_cnt);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data[5:0] !== {2'b01, 4'(i)}) begin
                errors++;
                $display("FAIL ovf_drain%0d: got v=%b d=%b want v=1 d=%b",
                         i, out_valid, out_data[5:0], {2'b01, 4'(i)});
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        checks++;
        if (out_valid !== 1'b0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_after: got v=%b o=%b want v=0 o=1",
                     out_valid, overflow);
        end
    endtask

    task automatic test_full_push_pop();
        logic [5:0] exp_q[$];
        logic [3:0] v;
        for (int i = 0; i < 8; i++) begin
            pulse_rco(4'(i));
            exp_q.push_back({2'b01, 4'(i)});
        end
        for (int n = 0; n < 20; n++) begin
            v = 4'((n * 7 + 3) % 16);
            checks++;
            if (out_data[5:0] !== exp_q[0]) begin
                errors++;
                $display("FAIL wrap%0d: got %b want %b",
                         n, out_data[5:0], exp_q[0]);
            end
            void'(exp_q.pop_front());
            exp_q.push_back({2'b01, v});
            q = v;
            rco = 1'b1;
            out_ready = 1'b1;
            tick();
            rco = 1'b0;
            out_ready = 1'b0;
            if (n == 0) begin
                checks++;
                if (level !== 4'd8 || drop_cnt !== 8'd2) begin
                    errors++;
                    $display("FAIL full_pp: got l=%0d c=%0d want l=8 c=2",
                             level, drop_cnt);
                end
            end
            tick();
        end
        checks++;
        if (level !== 4'd8 || drop_cnt !== 8'd2) begin
            errors++;
            $display("FAIL wrap_level: got l=%0d c=%0d want l=8 c=2",
                     level, drop_cnt);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (out_data[5:0] !== exp_q[i]) begin
                errors++;
                $display("FAIL wrap_drain%0d: got %b want %b",
                         i, out_data[5:0], exp_q[i]);
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        pulse_rco(4'h1);
        pulse_rco(4'h2);
        q = 4'h3;
        rco = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rco = 1'b0;
        checks++;
        if (level !== 4'd0 || overflow !== 1'b0 || drop_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid: got l=%0d o=%b c=%0d want 0 0 0",
                     level, overflow, drop_cnt);
        end
        // Strobe high at release is recorded on the first edge after reset.
        rco = 1'b1;
        q = 4'h9;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        rco = 1'b0;
        checks++;
        if (level !== 4'd1 || out_data[5:0] !== 6'b01_1001) begin
            errors++;
            $display("FAIL post_reset_ev: got l=%0d d=%b want l=1 d=011001",
                     level, out_data[5:0]);
        end
    endtask

`ifdef COUNT_EVENT_TIMESTAMP_EN
    task automatic test_timestamp();
        do_reset();
        cap_en = 1'b1;
        for (int e = 0; e < 5; e++) tick();
        rco = 1'b1;
        tick();
        rco = 1'b0;
        checks++;
        if (out_data[13:6] !== 8'd5) begin
            errors++;
            $display("FAIL ts5: got %0d want 5", out_data[13:6]);
        end
        out_ready = 1'b1;
        for (int e = 6; e < 300; e++) tick();
        out_ready = 1'b0;
        rco = 1'b1;
        tick();
        rco = 1'b0;
        checks++;
        if (out_data[13:6] !== 8'd44) begin
            errors++;
            $display("FAIL ts300: got %0d want 44", out_data[13:6]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_rco();
        test_held_and_both();
        test_overflow();
        test_full_push_pop();
        test_reset_mid();
`ifdef COUNT_EVENT_TIMESTAMP_EN
        test_timestamp();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
